// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide sequencer that sits in EX beside the ALU.
// An accepted op runs one bit per cycle:
//   - 32 shift-add steps for multiplies.
//   - 32 restoring steps for divides.
// It then spends one cycle applying signs and raises a one-cycle done pulse.
// Divide-by-zero and signed overflow skip the iteration and complete in the
// cycle after acceptance.
//
// Ports
//   clk     in   core clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   M-op present in EX (level)
//   op      in   funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   src1    in   forwarded rs1 operand, sampled on the accepting edge
//   src2    in   forwarded rs2 operand, sampled on the accepting edge
//   flush   in   abort the current operation
//   stall   out  freeze PC / IF/ID / ID/EX while the op is in progress
//   busy    out  high while iterating or fixing signs
//   done    out  one-cycle completion pulse, result valid
//   result  out  registered result, held until the next done
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ZERO_2W = {(2*WIDTH){1'b0}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Two's-complement negate of a single-width value when n is set.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    neg_if = n ? (ZERO_W - v) : v;
  endfunction

  // Two's-complement negate of a double-width value when n is set.
  function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic n);
    neg2_if = n ? (ZERO_2W - v) : v;
  endfunction

  state_t state_q, state_d;

  logic [2:0]         op_q;
  logic               neg1_q, neg2_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvs_q;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               src1_signed_s, src2_signed_s;
  logic               neg1_s, neg2_s;
  logic [WIDTH-1:0]   mag1_s, mag2_s;
  logic               div_zero_s, div_ovf_s, special_s;
  logic [WIDTH-1:0]   special_res_s;
  logic               accept_s;

  logic [2*WIDTH-1:0] prod_step_s;
  logic [WIDTH:0]     rem_shift_s;
  logic [WIDTH-1:0]   rem_sub_s;
  logic               qbit_s;

  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quot_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic [WIDTH-1:0]   fix_res_s;

  // Which operands are interpreted as signed for the incoming op.
  always_comb begin
    src1_signed_s = 1'b0;
    src2_signed_s = 1'b0;
    case (op)
      OP_MULH: begin
        src1_signed_s = 1'b1;
        src2_signed_s = 1'b1;
      end
      OP_MULHSU: begin
        src1_signed_s = 1'b1;
        src2_signed_s = 1'b0;
      end
      OP_DIV, OP_REM: begin
        src1_signed_s = 1'b1;
        src2_signed_s = 1'b1;
      end
      default: begin
        src1_signed_s = 1'b0;
        src2_signed_s = 1'b0;
      end
    endcase
  end

  // Magnitudes feed the unsigned datapath; signs are re-applied in FIX.
  // The magnitude of the most negative value is the same bit pattern, read unsigned.
  assign neg1_s = src1_signed_s & src1[WIDTH-1];
  assign neg2_s = src2_signed_s & src2[WIDTH-1];
  assign mag1_s = neg_if(src1, neg1_s);
  assign mag2_s = neg_if(src2, neg2_s);

  // DIV and REM (op[0]==0) are the signed divides that can overflow.
  assign div_zero_s = op[2] & (src2 == ZERO_W);
  assign div_ovf_s  = op[2] & ~op[0] & (src1 == MIN_NEG) & (src2 == ALL_ONES);
  assign special_s  = div_zero_s | div_ovf_s;

  // Architectural results for the cases that bypass iteration (op[1] selects REM*).
  always_comb begin
    special_res_s = ZERO_W;
    if (div_zero_s) begin
      special_res_s = op[1] ? src1 : ALL_ONES;
    end else begin
      special_res_s = op[1] ? ZERO_W : MIN_NEG;
    end
  end

  assign accept_s = (state_q == S_IDLE) & start & ~flush;

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    prod_step_s = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    rem_shift_s = {rem_q, dvd_q[WIDTH-1]};
    // The difference is always below the divisor, so WIDTH bits hold it exactly.
    if (rem_shift_s >= {1'b0, dvs_q}) begin
      rem_sub_s = rem_shift_s[WIDTH-1:0] - dvs_q;
      qbit_s    = 1'b1;
    end else begin
      rem_sub_s = rem_shift_s[WIDTH-1:0];
      qbit_s    = 1'b0;
    end
  end

  // Sign correction and output word selection.
  assign prod_fix_s = neg2_if(prod_q, neg1_q ^ neg2_q);
  assign quot_fix_s = neg_if(quot_q, neg1_q ^ neg2_q);
  assign rem_fix_s  = neg_if(rem_q, neg1_q);

  // Pick the architectural result word for the latched op.
  always_comb begin
    fix_res_s = ZERO_W;
    case (op_q)
      OP_MUL:                       fix_res_s = prod_fix_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_res_s = quot_fix_s;
      OP_REM, OP_REMU:              fix_res_s = rem_fix_s;
      default:                      fix_res_s = ZERO_W;
    endcase
  end

  // Next-state and registered-output logic of the sequencer.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (special_s) begin
            state_d  = S_DONE;
            result_d = special_res_s;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_DONE;
          result_d = fix_res_s;
        end
      end
      // start seen here belongs to the instruction now completing.
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CALC) | (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= ZERO_W;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Operand capture on acceptance, then one iteration per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= 3'b000;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      cnt_q    <= CNT_ZERO;
      prod_q   <= ZERO_2W;
      mcand_q  <= ZERO_2W;
      mplier_q <= ZERO_W;
      rem_q    <= ZERO_W;
      quot_q   <= ZERO_W;
      dvd_q    <= ZERO_W;
      dvs_q    <= ZERO_W;
    end else if (accept_s) begin
      op_q     <= op;
      neg1_q   <= neg1_s;
      neg2_q   <= neg2_s;
      cnt_q    <= CNT_ZERO;
      prod_q   <= ZERO_2W;
      mcand_q  <= {ZERO_W, mag1_s};
      mplier_q <= mag2_s;
      rem_q    <= ZERO_W;
      quot_q   <= ZERO_W;
      dvd_q    <= mag1_s;
      dvs_q    <= mag2_s;
    end else if (state_q == S_CALC) begin
      cnt_q    <= cnt_q + CNT_ONE;
      prod_q   <= prod_step_s;
      mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      rem_q    <= rem_sub_s;
      quot_q   <= {quot_q[WIDTH-2:0], qbit_s};
      dvd_q    <= {dvd_q[WIDTH-2:0], 1'b0};
    end
  end

  // The accepting-cycle term must hold the instruction in EX before any state
  // change, hence combinational; reset forces it low like the other outputs.
  assign stall  = ~rst & (accept_s | busy_q);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, flush / reset
// sequences, and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  // RV32M semantics computed with plain 64-bit / signed arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    ref_result = 32'd0;
    case (o)
      3'd0: begin p = ua * ub; ref_result = p[31:0];  end
      3'd1: begin p = sa * sb; ref_result = p[63:32]; end
      3'd2: begin p = sa * ub; ref_result = p[63:32]; end
      3'd3: begin p = ua * ub; ref_result = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) ref_result = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ref_result = 32'h80000000;
        else ref_result = ia / ib;
      end
      3'd5: ref_result = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'd0) ref_result = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ref_result = 32'd0;
        else ref_result = ia % ib;
      end
      default: ref_result = (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Cycles from start to done: 1 for divide-by-zero / signed overflow, else 34.
  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 32'd0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      ref_latency = 1;
    else
      ref_latency = 34;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op, hold start until done, then drop start for one idle cycle.
  // post reports busy|stall|done in that idle cycle (nothing must relaunch).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output logic [31:0] res, output int lat,
                        output int stl, output logic post);
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    lat = -1; stl = 0; res = 32'd0;
    for (int k = 0; k < 60; k++) begin
      if (scramble && k >= 1) begin
        src1 = $urandom; src2 = $urandom; op = 3'($urandom_range(0, 7));
      end
      #1;
      if (stall) stl++;
      if (done) begin
        lat = k;
        res = result;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    post = busy | stall | done;
  endtask

  initial begin
    logic [31:0] res;
    int          lat, stl, el;
    logic        post;
    logic        seen;
    logic [2:0]  o;
    logic [31:0] a, b;
    int          m;

    vecs[0]  = '{3'd0, 32'd7,          32'd6,          32'h0000002A, 34};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 34};
    vecs[2]  = '{3'd1, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF, 34};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF, 34};
    vecs[4]  = '{3'd0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 34};
    vecs[5]  = '{3'd4, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 34};
    vecs[6]  = '{3'd6, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF, 34};
    vecs[7]  = '{3'd5, 32'd100,        32'd7,          32'd14,       34};
    vecs[8]  = '{3'd7, 32'd100,        32'd7,          32'd2,        34};
    vecs[9]  = '{3'd4, 32'd5,          32'd0,          32'hFFFFFFFF, 1};
    vecs[10] = '{3'd7, 32'd5,          32'd0,          32'd5,        1};
    vecs[11] = '{3'd4, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1};
    vecs[12] = '{3'd6, 32'h80000000,   32'hFFFFFFFF,   32'd0,        1};
    vecs[13] = '{3'd1, 32'h80000000,   32'h80000000,   32'h40000000, 34};
    vecs[14] = '{3'd6, 32'd7,          32'hFFFFFFFE,   32'd1,        34};
    vecs[15] = '{3'd5, 32'd100,        32'd7,          32'd14,       34};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; src1 = 32'd0; src2 = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", stall, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, res, lat, stl, post);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_stall_cycles", i), stl, vecs[i].lat);
      chk($sformatf("vec%0d_no_relaunch", i), post, 0);
    end

    // Flush at cycle 10 of a MUL; result keeps 14 from the last vector.
    @(negedge clk);
    start = 1'b1; op = 3'd0; src1 = 32'd5; src2 = 32'd5;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk("flush_busy", busy, 0);
    chk("flush_stall", stall, 0);
    seen = done;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      seen = seen | done | busy;
    end
    chk("flush_no_done", seen, 0);
    chk("flush_result_held", result, 32'd14);

    // start together with flush in IDLE is not accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0; src1 = 32'd3; src2 = 32'd3;
    #1;
    chk("flush_start_stall", stall, 0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_start_busy", busy, 0);

    run_op(3'd0, 32'd3, 32'd3, 1'b0, res, lat, stl, post);
    chk("after_flush_result", res, 32'd9);
    chk("after_flush_latency", lat, 34);

    // Asynchronous reset in cycle 20 of a DIVU.
    @(negedge clk);
    start = 1'b1; op = 3'd5; src1 = 32'd1000; src2 = 32'd3;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_stall", stall, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      seen = seen | done | busy | stall;
    end
    chk("midrst_idle_after", seen, 0);
    run_op(3'd5, 32'd1000, 32'd3, 1'b0, res, lat, stl, post);
    chk("after_rst_result", res, 32'd333);

    // Randomized ops; operands and op are scrambled after acceptance.
    for (int i = 0; i < 150; i++) begin
      m = $urandom_range(0, 9);
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (m == 0) b = 32'd0;
      else if (m == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (m == 2) begin a = $urandom_range(0, 100); b = $urandom_range(0, 20); end
      else if (m == 3) b = $urandom_range(1, 15);
      el = ref_latency(o, a, b);
      run_op(o, a, b, 1'b1, res, lat, stl, post);
      chk($sformatf("rnd%0d_op%0d_%h_%h_result", i, o, a, b), res, ref_result(o, a, b));
      chk($sformatf("rnd%0d_latency", i), lat, el);
      chk($sformatf("rnd%0d_stall_cycles", i), stl, el);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
